// File: rtl/nibble_packer.sv
// nibble_packer: gathers up to four nibbles per beat into an A/B word pair
// and hands the completed pair to the word datapath over valid/ready.
module nibble_packer #(
   parameter int NLANES = 4,
   parameter int CNT_W  = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [NLANES-1:0]    lane_en,
   input  logic [4*NLANES-1:0]  nib_in,
   input  logic [3*NLANES-1:0]  pos_in,
   input  logic [NLANES-1:0]    dst_b,
   input  logic                 flush,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          DATA_A,
   output logic [31:0]          DATA_B,
   output logic [7:0]           MASK_A,
   output logic [7:0]           MASK_B,
   output logic                 overwrite_err,
   output logic [CNT_W-1:0]     pair_count
);
   typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;
   state_t             state_q, state_d;
   logic [31:0]        data_a_q, data_a_d, data_b_q, data_b_d;
   logic [7:0]         mask_a_q, mask_a_d, mask_b_q, mask_b_d;
   logic               err_q, err_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               beat, done, handoff, hit;
   logic [31:0]        wa, wb;
   logic [7:0]         ma, mb;
   // Lanes are applied in ascending order so the highest lane wins a collision;
   // overwrite detection looks only at the pre-beat masks.
   always_comb begin
      beat = in_valid && (state_q == FILL);
      wa   = data_a_q;
      wb   = data_b_q;
      ma   = mask_a_q;
      mb   = mask_b_q;
      hit  = 1'b0;
      for (int i = 0; i < NLANES; i++)
         if (beat && lane_en[i]) begin
            if (dst_b[i]) begin
               hit = hit | mask_b_q[pos_in[3*i+:3]];
               wb[{pos_in[3*i+:3], 2'b00} +: 4] = nib_in[4*i+:4];
               mb[pos_in[3*i+:3]] = 1'b1;
            end else begin
               hit = hit | mask_a_q[pos_in[3*i+:3]];
               wa[{pos_in[3*i+:3], 2'b00} +: 4] = nib_in[4*i+:4];
               ma[pos_in[3*i+:3]] = 1'b1;
            end
         end
      done = (&ma && &mb) || (flush && |{ma, mb});
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) state_q <= FILL;
      else       state_q <= state_d;
   always_comb
      state_d = (state_q == FILL) ? (done ? HOLD : FILL) : (out_ready ? FILL : HOLD);
   always_comb begin
      in_ready      = (state_q == FILL);
      out_valid     = (state_q == HOLD);
      DATA_A        = data_a_q;
      DATA_B        = data_b_q;
      MASK_A        = mask_a_q;
      MASK_B        = mask_b_q;
      overwrite_err = err_q;
      pair_count    = cnt_q;
   end
   // In HOLD no beat is accepted, so wa/wb/ma/mb simply echo the held pair.
   always_comb begin
      handoff  = (state_q == HOLD) && out_ready;
      data_a_d = handoff ? '0 : wa;
      data_b_d = handoff ? '0 : wb;
      mask_a_d = handoff ? '0 : ma;
      mask_b_d = handoff ? '0 : mb;
      err_d    = hit;
      cnt_d    = cnt_q + CNT_W'(handoff);
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         data_a_q <= '0;
         data_b_q <= '0;
         mask_a_q <= '0;
         mask_b_q <= '0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
      end else begin
         data_a_q <= data_a_d;
         data_b_q <= data_b_d;
         mask_a_q <= mask_a_d;
         mask_b_q <= mask_b_d;
         err_q    <= err_d;
         cnt_q    <= cnt_d;
      end
endmodule

// File: tb/tb_nibble_packer.sv
// tb_nibble_packer: directed vectors with hand-computed expectations for nibble_packer.
module tb_nibble_packer;
   logic        clk, reset, in_valid, in_ready, flush, out_valid, out_ready, overwrite_err;
   logic [3:0]  lane_en, dst_b;
   logic [15:0] nib_in;
   logic [11:0] pos_in;
   logic [31:0] DATA_A, DATA_B;
   logic [7:0]  MASK_A, MASK_B, pair_count;
   int          n_checks = 0;
   int          n_errors = 0;
   nibble_packer #(.NLANES(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .lane_en(lane_en), .nib_in(nib_in), .pos_in(pos_in), .dst_b(dst_b),
      .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
      .DATA_A(DATA_A), .DATA_B(DATA_B), .MASK_A(MASK_A), .MASK_B(MASK_B),
      .overwrite_err(overwrite_err), .pair_count(pair_count)
   );
   initial clk = 1'b0;
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask
   task automatic drive(input logic v, input logic [3:0] en, input logic [15:0] nib,
                        input logic [11:0] pos, input logic [3:0] dst, input logic fl,
                        input logic rdy);
      in_valid  = v;
      lane_en   = en;
      nib_in    = nib;
      pos_in    = pos;
      dst_b     = dst;
      flush     = fl;
      out_ready = rdy;
      @(posedge clk);
      #1;
   endtask
   task automatic idle();
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b0, 1'b0);
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end
   initial begin
      reset = 1'b0;
      in_valid = 1'b0; lane_en = '0; nib_in = '0; pos_in = '0; dst_b = '0;
      flush = 1'b0; out_ready = 1'b0;
      #2 reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_data_a", DATA_A, 0);
      check("rst_mask", {MASK_A, MASK_B}, 0);
      check("rst_count", 32'(pair_count), 0);
      check("rst_err", 32'(overwrite_err), 0);
      reset = 1'b0;
      idle();
      check("rst_in_ready", 32'(in_ready), 1);
      // Four beats fill both words
      drive(1'b1, 4'hF, 16'h4321, {3'd3, 3'd2, 3'd1, 3'd0}, 4'h0, 1'b0, 1'b0);
      drive(1'b1, 4'hF, 16'hCBA9, {3'd3, 3'd2, 3'd1, 3'd0}, 4'hF, 1'b0, 1'b0);
      drive(1'b1, 4'hF, 16'h8765, {3'd7, 3'd6, 3'd5, 3'd4}, 4'h0, 1'b0, 1'b0);
      check("partial_out_valid", 32'(out_valid), 0);
      check("partial_mask", {MASK_A, MASK_B}, 32'hFF0F);
      drive(1'b1, 4'hF, 16'h0FED, {3'd7, 3'd6, 3'd5, 3'd4}, 4'hF, 1'b0, 1'b0);
      check("full_out_valid", 32'(out_valid), 1);
      check("full_in_ready", 32'(in_ready), 0);
      check("full_data_a", DATA_A, 32'h87654321);
      check("full_data_b", DATA_B, 32'h0FEDCBA9);
      check("full_masks", {MASK_A, MASK_B}, 32'hFFFF);
      check("full_err", 32'(overwrite_err), 0);
      // Back-pressure: held pair must not move
      for (int k = 0; k < 5; k++) begin
         drive(1'b1, 4'($urandom), 16'($urandom), 12'($urandom), 4'($urandom), 1'($urandom), 1'b0);
         check("hold_valid", 32'(out_valid), 1);
         check("hold_data_a", DATA_A, 32'h87654321);
         check("hold_data_b", DATA_B, 32'h0FEDCBA9);
         check("hold_err", 32'(overwrite_err), 0);
      end
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b0, 1'b1);
      check("rel_out_valid", 32'(out_valid), 0);
      check("rel_data", DATA_A | DATA_B, 0);
      check("rel_mask", {MASK_A, MASK_B}, 0);
      check("rel_count", 32'(pair_count), 1);
      check("rel_in_ready", 32'(in_ready), 1);
      // Single nibble then flush
      drive(1'b1, 4'h1, 16'h0005, 12'h007, 4'h0, 1'b0, 1'b0);
      check("single_fill", 32'(out_valid), 0);
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b1, 1'b0);
      check("flush_valid", 32'(out_valid), 1);
      check("flush_data_a", DATA_A, 32'h50000000);
      check("flush_mask_a", 32'(MASK_A), 32'h80);
      check("flush_data_b", DATA_B, 0);
      check("flush_mask_b", 32'(MASK_B), 0);
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b0, 1'b1);
      check("flush_count", 32'(pair_count), 2);
      // Same-beat collision: lane3 beats lane1, no error
      drive(1'b1, 4'hA, 16'h9010, {3'd2, 3'd0, 3'd2, 3'd0}, 4'h0, 1'b0, 1'b0);
      check("coll_data_a", DATA_A, 32'h00000900);
      check("coll_mask_a", 32'(MASK_A), 32'h04);
      check("coll_err", 32'(overwrite_err), 0);
      drive(1'b1, 4'h1, 16'h0004, 12'h002, 4'h0, 1'b0, 1'b0);
      check("ovw_err", 32'(overwrite_err), 1);
      check("ovw_data_a", DATA_A, 32'h00000400);
      idle();
      check("ovw_err_pulse", 32'(overwrite_err), 0);
      // Same nibble of B is a different slot: no error
      drive(1'b1, 4'h1, 16'h0003, 12'h002, 4'h1, 1'b0, 1'b0);
      check("b_no_err", 32'(overwrite_err), 0);
      check("b_data", DATA_B, 32'h00000300);
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b1, 1'b0);
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b0, 1'b1);
      check("coll_count", 32'(pair_count), 3);
      // Flush with nothing written is ignored, also with a no-op beat
      drive(1'b0, 4'h0, 16'h0, 12'h0, 4'h0, 1'b1, 1'b0);
      check("empty_flush", 32'(out_valid), 0);
      drive(1'b1, 4'h0, 16'hFFFF, 12'h0, 4'h0, 1'b1, 1'b0);
      check("noop_flush", 32'(out_valid), 0);
      check("noop_ready", 32'(in_ready), 1);
      // Reset during HOLD
      drive(1'b1, 4'h2, 16'h00B0, 12'h008, 4'h0, 1'b1, 1'b0);
      check("pre_rst_valid", 32'(out_valid), 1);
      check("pre_rst_data", DATA_A, 32'h000000B0);
      #2 reset = 1'b1;
      #1;
      check("async_rst_valid", 32'(out_valid), 0);
      check("async_rst_count", 32'(pair_count), 0);
      @(posedge clk);
      #1 reset = 1'b0;
      idle();
      check("post_rst_ready", 32'(in_ready), 1);
      check("post_rst_count", 32'(pair_count), 0);
      check("post_rst_data", DATA_A, 0);
      // 256 handoffs wrap the counter; flush with a beat carries that beat
      drive(1'b1, 4'h1, 16'h000A, 12'h0, 4'h0, 1'b1, 1'b1);
      check("wrap_first", DATA_A, 32'h0000000A);
      check("wrap_first_valid", 32'(out_valid), 1);
      for (int k = 0; k < 509; k++) drive(1'b1, 4'h1, 16'h000A, 12'h0, 4'h0, 1'b1, 1'b1);
      check("wrap_255", 32'(pair_count), 255);
      check("wrap_255_fill", 32'(in_ready), 1);
      drive(1'b1, 4'h1, 16'h000A, 12'h0, 4'h0, 1'b1, 1'b1);
      drive(1'b1, 4'h1, 16'h000A, 12'h0, 4'h0, 1'b1, 1'b1);
      check("wrap_0", 32'(pair_count), 0);
      idle();
      check("wrap_idle_count", 32'(pair_count), 0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
